req_encoder_4to2: RTL

//  Sequential priority encoder, the inverse of the 2-to-4 decoder path.

---
 rtl/encoder_pkg.sv | 25 ++
 rtl/prio_enc_comb.sv | 43 ++++
 rtl/req_encoder_4to2.sv | 128 ++++++++++++
 3 files changed

// File: rtl/encoder_pkg.sv
// encoder_pkg: shared types and helpers for the sequential request encoder.
//   state_e    FSM state encoding (IDLE / SERVE)
//   clog2()    ceiling log2, used to derive the index width from N_REQ
//   ENC_*      default sizing for a 4-request encoder
package encoder_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SERVE = 1'b1
    } state_e;

    // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((32'(1) << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int unsigned ENC_N_REQ = 4;
    localparam int unsigned ENC_IDX_W = clog2(ENC_N_REQ);

endpackage : encoder_pkg

// File: rtl/prio_enc_comb.sv
// prio_enc_comb: purely combinational priority encoder over a request vector.
//   req           in   N_REQ  request vector, bit i requests index i
//   idx           out  IDX_W  index of the highest set bit (0 when none set)
//   any_set       out  1      at least one bit of req is set
//   one_hot_only  out  1      exactly one bit of req is set
module prio_enc_comb
    import encoder_pkg::*;
#(
    parameter int unsigned N_REQ = ENC_N_REQ,
    parameter int unsigned IDX_W = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    output logic [IDX_W-1:0] idx,
    output logic             any_set,
    output logic             one_hot_only
);

    logic [1:0] set_cnt;

    // Ascending scan: the last set bit seen is the highest one.
    always_comb begin
        idx = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    // Popcount saturating at 2: only "none / one / more than one" matters.
    always_comb begin
        set_cnt = 2'd0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (req[i] && (set_cnt != 2'd2)) begin
                set_cnt = set_cnt + 2'd1;
            end
        end
    end

    assign any_set      = |req;
    assign one_hot_only = (set_cnt == 2'd1);

endmodule : prio_enc_comb

// File: rtl/req_encoder_4to2.sv
// req_encoder_4to2: sequential priority encoder. Captures a request vector and
// streams the index of every set bit, highest index first, over valid/ready.
//   clk        in   1      rising-edge clock
//   rst_n      in   1      synchronous active-low reset
//   in_valid   in   1      in_req is valid
//   in_ready   out  1      a new vector can be accepted (IDLE only)
//   in_req     in   N_REQ  request vector, bit i requests index i
//   out_valid  out  1      out_idx / out_last are valid
//   out_ready  in   1      downstream accepts the current index
//   out_idx    out  IDX_W  highest pending index
//   out_last   out  1      out_idx is the final pending index of this vector
//   zero_err   out  1      one-cycle pulse: an all-zero vector was accepted
module req_encoder_4to2
    import encoder_pkg::*;
#(
    parameter int unsigned N_REQ = ENC_N_REQ,
    parameter int unsigned IDX_W = ENC_IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_REQ-1:0] in_req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             zero_err
);

    // Elaboration-time sanity check of the sizing parameters.
    if ((N_REQ < 2) || ((N_REQ & (N_REQ - 1)) != 0) || (IDX_W != clog2(N_REQ))) begin : g_param_chk
        $error("req_encoder_4to2: N_REQ must be a power of two >= 2 and IDX_W = clog2(N_REQ)");
    end

    state_e             state_q,     state_d;
    logic [N_REQ-1:0]   pending_q,   pending_d;
    logic               in_ready_q,  in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               zero_err_q,  zero_err_d;

    logic [IDX_W-1:0]   enc_idx;
    logic               enc_any;
    logic               enc_one_hot;
    logic [N_REQ-1:0]   clr_mask;
    logic               accept;
    logic               xfer;

    // Priority view of the registered pending set.
    prio_enc_comb #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .req          (pending_q),
        .idx          (enc_idx),
        .any_set      (enc_any),
        .one_hot_only (enc_one_hot)
    );

    // in_ready_q is only ever 1 in IDLE, so it alone qualifies acceptance.
    assign accept = in_valid && in_ready_q;
    assign xfer   = out_valid_q && out_ready;

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        zero_err_d = 1'b0;
        clr_mask   = '0;
        clr_mask[enc_idx] = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (|in_req) begin
                        pending_d = in_req;
                        state_d   = ST_SERVE;
                    end else begin
                        zero_err_d = 1'b1;
                    end
                end
            end
            ST_SERVE: begin
                if (!enc_any) begin
                    // Defensive: nothing left to serve.
                    state_d = ST_IDLE;
                end else if (xfer) begin
                    pending_d = pending_q & ~clr_mask;
                    if (enc_one_hot) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                pending_d = '0;
            end
        endcase

        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_SERVE);
    end

    // State and output registers; reset drops any partially served vector.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pending_q   <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            zero_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            zero_err_q  <= zero_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign zero_err  = zero_err_q;
    // Decoded from the registered pending set; both read 0 whenever pending is empty.
    assign out_idx   = enc_idx;
    assign out_last  = enc_one_hot;

endmodule : req_encoder_4to2
